disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Digit-scan sequencer for an 8-digit multiplexed display: drives decoder index/enable and the active nibble.
// Optional dead time between digits is enabled by defining DISP_SCAN_BLANK_EN.
module disp_scan_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  digit_mask,
    input  logic [31:0] data_in,
    output logic [2:0]  sel,
    output logic        sel_en,
    output logic [3:0]  nibble,
    output logic        frame_start
);

    localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHOW  = 2'd1;
`ifdef DISP_SCAN_BLANK_EN
    localparam logic [1:0] BLANK = 2'd2;
    localparam int BLK_W = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
`endif

    if (CLK_DIV < 2 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("disp_scan_ctrl: CLK_DIV must be >= 2 and BLANK_CYCLES >= 1");
    end

    function automatic logic [2:0] lowest_set(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Cyclic search from cur+1; falls back to cur itself when no other digit is enabled.
    function automatic logic [2:0] next_set(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] idx;
        logic [2:0] cand;
        idx = cur;
        for (int k = 7; k >= 1; k--) begin
            cand = cur + 3'(k);
            if (mask[cand]) idx = cand;
        end
        return idx;
    endfunction

    logic [1:0]       state, state_nxt;
    logic [PRE_W-1:0] prescaler, pre_nxt;
    logic [2:0]       sel_nxt;
    logic             sel_en_nxt;
    logic             frame_nxt;
    logic             stop;
    logic [2:0]       lowest;
    logic [2:0]       following;
`ifdef DISP_SCAN_BLANK_EN
    logic [BLK_W-1:0] blank_cnt, blank_nxt;
`endif

    assign stop      = !en || (digit_mask == 8'd0);
    assign lowest    = lowest_set(digit_mask);
    assign following = next_set(sel, digit_mask);

    always_comb begin
        state_nxt  = state;
        pre_nxt    = prescaler;
        sel_nxt    = sel;
        sel_en_nxt = sel_en;
        frame_nxt  = 1'b0;
`ifdef DISP_SCAN_BLANK_EN
        blank_nxt  = blank_cnt;
`endif
        case (state)
            IDLE: begin
                sel_en_nxt = 1'b0;
                pre_nxt    = '0;
                if (!stop) begin
                    state_nxt  = SHOW;
                    sel_nxt    = lowest;
                    sel_en_nxt = 1'b1;
                    frame_nxt  = 1'b1;
                end
            end
            SHOW: begin
                if (stop) begin
                    state_nxt  = IDLE;
                    sel_en_nxt = 1'b0;
                    pre_nxt    = '0;
                end else if (prescaler == PRE_LAST) begin
                    pre_nxt   = '0;
                    sel_nxt   = following;
                    frame_nxt = (following == lowest);
`ifdef DISP_SCAN_BLANK_EN
                    state_nxt  = BLANK;
                    sel_en_nxt = 1'b0;
                    blank_nxt  = '0;
`endif
                end else begin
                    pre_nxt = prescaler + PRE_W'(1);
                end
            end
`ifdef DISP_SCAN_BLANK_EN
            BLANK: begin
                sel_en_nxt = 1'b0;
                if (stop) begin
                    state_nxt = IDLE;
                    pre_nxt   = '0;
                end else if (blank_cnt == BLK_LAST) begin
                    state_nxt  = SHOW;
                    sel_en_nxt = 1'b1;
                    pre_nxt    = '0;
                end else begin
                    blank_nxt = blank_cnt + BLK_W'(1);
                end
            end
`endif
            default: begin
                state_nxt  = IDLE;
                sel_en_nxt = 1'b0;
                pre_nxt    = '0;
            end
        endcase
    end

    // nibble follows the index being loaded this edge, so data changes show one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prescaler   <= '0;
            sel         <= 3'd0;
            sel_en      <= 1'b0;
            nibble      <= 4'd0;
            frame_start <= 1'b0;
`ifdef DISP_SCAN_BLANK_EN
            blank_cnt   <= '0;
`endif
        end else begin
            state       <= state_nxt;
            prescaler   <= pre_nxt;
            sel         <= sel_nxt;
            sel_en      <= sel_en_nxt;
            nibble      <= data_in[{sel_nxt, 2'b00} +: 4];
            frame_start <= frame_nxt;
`ifdef DISP_SCAN_BLANK_EN
            blank_cnt   <= blank_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard testbench for disp_scan_ctrl (default parameters, CLK_DIV=4, BLANK_CYCLES=2).
// Expected output tuples {sel, sel_en, nibble, frame_start} are queued per cycle and popped after each edge.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  digit_mask;
    logic [31:0] data_in;
    logic [2:0]  sel;
    logic        sel_en;
    logic [3:0]  nibble;
    logic        frame_start;

    int errors;
    int checks;
    logic [8:0] exp_q[$];

    disp_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digit_mask  (digit_mask),
        .data_in     (data_in),
        .sel         (sel),
        .sel_en      (sel_en),
        .nibble      (nibble),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] digit_of(input logic [31:0] w, input int d);
        return w[4*d +: 4];
    endfunction

    function automatic void push_exp(input logic [2:0] s, input logic e, input logic [3:0] n, input logic f);
        exp_q.push_back({s, e, n, f});
    endfunction

    task automatic applyStimulus(input logic e, input logic [7:0] m, input logic [31:0] d);
        en         = e;
        digit_mask = m;
        data_in    = d;
    endtask

    // Drop en for one edge so the next scan starts from IDLE.
    task automatic go_idle();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hFF, 32'hFEDC_BA98);
        for (int i = 0; i < 3; i++) push_exp(3'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL reset cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_scan();
        logic [8:0] e;
        int i;
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 8; d++)
                for (int c = 0; c < 4; c++)
                    push_exp(3'(d), 1'b1, digit_of(data_in, d), (d == 0 && c == 0));
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL full_scan cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
            i++;
        end
    endtask

    task automatic test_mask_skip();
        logic [8:0] e;
        int i;
        int seq[3] = '{0, 2, 7};
        go_idle();
        applyStimulus(1'b1, 8'b1000_0101, 32'h8765_4321);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 4; c++)
                    push_exp(3'(seq[k]), 1'b1, digit_of(data_in, seq[k]), (seq[k] == 0 && c == 0));
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL mask_skip cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
            i++;
        end
    endtask

    task automatic test_single_digit();
        logic [8:0] e;
        int i;
        go_idle();
        applyStimulus(1'b1, 8'h10, 32'h8765_4321);
        for (int k = 0; k < 12; k++)
            push_exp(3'd4, 1'b1, (k <= 6) ? 4'h5 : 4'hA, (k % 4 == 0));
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL single_digit cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
            if (i == 6) data_in = 32'h876A_4321;
            i++;
        end
    endtask

    task automatic test_disable();
        logic [8:0] e;
        int i;
        go_idle();
        applyStimulus(1'b1, 8'hFF, 32'hFEDC_BA98);
        for (int k = 0; k < 14; k++)
            push_exp(3'(k / 4), 1'b1, digit_of(data_in, k / 4), (k == 0));
        for (int k = 0; k < 3; k++) push_exp(3'd3, 1'b0, digit_of(data_in, 3), 1'b0);
        for (int k = 0; k < 4; k++) push_exp(3'd0, 1'b1, digit_of(data_in, 0), (k == 0));
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL disable cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
            if (i == 13) en = 1'b0;
            if (i == 16) en = 1'b1;
            i++;
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [8:0] e;
        int i;
        go_idle();
        applyStimulus(1'b1, 8'hFF, 32'hFEDC_BA98);
        for (int k = 0; k < 26; k++)
            push_exp(3'(k / 4), 1'b1, digit_of(data_in, k / 4), (k == 0));
        push_exp(3'd0, 1'b0, 4'd0, 1'b0);
        push_exp(3'd0, 1'b1, digit_of(data_in, 0), 1'b1);
        push_exp(3'd0, 1'b1, digit_of(data_in, 0), 1'b0);
        push_exp(3'd0, 1'b0, digit_of(data_in, 0), 1'b0);
        push_exp(3'd0, 1'b0, digit_of(data_in, 0), 1'b0);
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid_scan cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
            if (i == 25) rst_n = 1'b0;
            if (i == 26) rst_n = 1'b1;
            if (i == 28) digit_mask = 8'h00;
            i++;
        end
        digit_mask = 8'hFF;
    endtask

`ifdef DISP_SCAN_BLANK_EN
    task automatic test_blank();
        logic [8:0] e;
        int i;
        int d;
        go_idle();
        applyStimulus(1'b1, 8'hFF, 32'hFEDC_BA98);
        for (int c = 0; c < 4; c++) push_exp(3'd0, 1'b1, digit_of(data_in, 0), (c == 0));
        for (int k = 1; k <= 9; k++) begin
            d = k % 8;
            for (int c = 0; c < 2; c++) push_exp(3'(d), 1'b0, digit_of(data_in, d), (d == 0 && c == 0));
            for (int c = 0; c < 4; c++) push_exp(3'(d), 1'b1, digit_of(data_in, d), 1'b0);
        end
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sel, sel_en, nibble, frame_start} !== e) begin
                errors++;
                $display("[TB] FAIL blank cyc %0d: got sel=%0d sel_en=%b nibble=%h frame=%b, expected sel=%0d sel_en=%b nibble=%h frame=%b",
                         i, sel, sel_en, nibble, frame_start, e[8:6], e[5], e[4:1], e[0]);
            end
            i++;
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 8'h00, 32'h0);
        test_reset();
`ifdef DISP_SCAN_BLANK_EN
        test_blank();
`else
        test_full_scan();
        test_mask_skip();
        test_single_digit();
        test_disable();
        test_reset_mid_scan();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
